l2_resp_scheduler: RTL and testbench

- Sits between N_SLAVE L2 bank response ports and the L2 response fan-in tree.
- Buffers one response per bank and grants exactly one buffered response per transfer, round-robin.
- Drives a strictly one-hot valid vector into the tree, which merges responses without arbitration.
- Holds the granted response in an output register until the master accepts it with resp_ready_i.

---
 rtl/l2_resp_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_l2_resp_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_resp_scheduler.sv
// l2_resp_scheduler
// Buffers one response per L2 bank, grants one buffered response per transfer
// in round-robin order, and presents it on a strictly one-hot lane of the
// response fan-in tree. The granted response sits in an output register until
// the master accepts it with resp_ready_i.
module l2_resp_scheduler #(
    parameter int N_SLAVE    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_NUM   = DATA_WIDTH / 8,
    parameter int TAG_WIDTH  = BYTE_NUM
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_SLAVE-1:0]              bank_valid_i,
    input  logic [N_SLAVE*DATA_WIDTH-1:0]   bank_rdata_i,
    input  logic [N_SLAVE*TAG_WIDTH-1:0]    bank_rtag_i,
    output logic [N_SLAVE-1:0]              bank_ready_o,
    output logic [N_SLAVE-1:0]              tree_valid_o,
    output logic [N_SLAVE*DATA_WIDTH-1:0]   tree_rdata_o,
    output logic [N_SLAVE*TAG_WIDTH-1:0]    tree_rtag_o,
    input  logic                            resp_ready_i,
    output logic                            busy_o
);

    // Index width; a single bank still gets a 1-bit index that stays at zero.
    localparam int SEL_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
    // Bank count in index width plus one bit, so rr_ptr + offset never overflows.
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N_SLAVE);

    // Per-bank response buffers
    logic [N_SLAVE-1:0]    buf_valid_q, buf_valid_d;
    logic [DATA_WIDTH-1:0] buf_data_q [N_SLAVE];
    logic [DATA_WIDTH-1:0] buf_data_d [N_SLAVE];
    logic [TAG_WIDTH-1:0]  buf_tag_q  [N_SLAVE];
    logic [TAG_WIDTH-1:0]  buf_tag_d  [N_SLAVE];

    // Output register and round-robin pointer
    logic                  out_valid_q, out_valid_d;
    logic [SEL_W-1:0]      out_sel_q,   out_sel_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [TAG_WIDTH-1:0]  out_tag_q,   out_tag_d;
    logic [SEL_W-1:0]      rr_ptr_q,    rr_ptr_d;

    // Arbitration / handshake signals
    logic                  load_s;
    logic                  found_s;
    logic [SEL_W-1:0]      sel_s;
    logic [SEL_W:0]        cand_s;
    logic [SEL_W:0]        next_ptr_s;
    logic [N_SLAVE-1:0]    pop_s;

    // The output register can take a new response when empty or being drained.
    assign load_s = ~out_valid_q | resp_ready_i;

    // Round-robin search starting at rr_ptr; the candidate index wraps at N_SLAVE
    // so a non-power-of-two bank count never produces an out-of-range index.
    always_comb begin
        found_s = 1'b0;
        sel_s   = {SEL_W{1'b0}};
        cand_s  = {(SEL_W+1){1'b0}};
        for (int k = 0; k < N_SLAVE; k++) begin
            cand_s = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
            if (cand_s >= N_EXT) begin
                cand_s = cand_s - N_EXT;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && buf_valid_q[cand_s[SEL_W-1:0]]) begin
                found_s = 1'b1;
                sel_s   = cand_s[SEL_W-1:0];
            end else begin
                found_s = found_s;
                sel_s   = sel_s;
            end
        end
    end

    // Pointer moves to the bank after the granted one, wrapping at N_SLAVE.
    always_comb begin
        next_ptr_s = {1'b0, sel_s} + {{SEL_W{1'b0}}, 1'b1};
        if (next_ptr_s >= N_EXT) begin
            next_ptr_s = {(SEL_W+1){1'b0}};
        end else begin
            next_ptr_s = next_ptr_s;
        end
    end

    // Pop decode and bank ready: a full buffer is ready only when it is emptied
    // this cycle, which makes bank_ready_o depend combinationally on resp_ready_i.
    always_comb begin
        pop_s        = {N_SLAVE{1'b0}};
        bank_ready_o = {N_SLAVE{1'b0}};
        for (int i = 0; i < N_SLAVE; i++) begin
            pop_s[i]        = load_s & found_s & (sel_s == SEL_W'(i));
            bank_ready_o[i] = ~buf_valid_q[i] | pop_s[i];
        end
    end

    // Buffer next state: a push wins over a same-cycle pop so back-to-back
    // responses from one bank keep the buffer full with the newer data.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_tag_d   = buf_tag_q;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (bank_valid_i[i] && bank_ready_o[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_data_d[i]  = bank_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                buf_tag_d[i]   = bank_rtag_i[i*TAG_WIDTH +: TAG_WIDTH];
            end else if (pop_s[i]) begin
                buf_valid_d[i] = 1'b0;
            end else begin
                buf_valid_d[i] = buf_valid_q[i];
            end
        end
    end

    // Output register next state: load the granted buffer, go empty when there
    // is nothing to grant, and hold everything while the master stalls.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_s && found_s) begin
            out_valid_d = 1'b1;
            out_sel_d   = sel_s;
            out_data_d  = buf_data_q[sel_s];
            out_tag_d   = buf_tag_q[sel_s];
            rr_ptr_d    = next_ptr_s[SEL_W-1:0];
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Buffer registers; reset discards any buffered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= {N_SLAVE{1'b0}};
            for (int i = 0; i < N_SLAVE; i++) begin
                buf_data_q[i] <= {DATA_WIDTH{1'b0}};
                buf_tag_q[i]  <= {TAG_WIDTH{1'b0}};
            end
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_tag_q   <= buf_tag_d;
        end
    end

    // Output register and pointer; reset drops the in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sel_q   <= {SEL_W{1'b0}};
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_tag_q   <= {TAG_WIDTH{1'b0}};
            rr_ptr_q    <= {SEL_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Tree drive: only the granted lane carries valid, data and tag; the tree
    // merges lanes without arbitration, so every other lane is forced to zero.
    always_comb begin
        tree_valid_o = {N_SLAVE{1'b0}};
        tree_rdata_o = {(N_SLAVE*DATA_WIDTH){1'b0}};
        tree_rtag_o  = {(N_SLAVE*TAG_WIDTH){1'b0}};
        for (int i = 0; i < N_SLAVE; i++) begin
            if (out_valid_q && (out_sel_q == SEL_W'(i))) begin
                tree_valid_o[i]                          = 1'b1;
                tree_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = out_data_q;
                tree_rtag_o[i*TAG_WIDTH +: TAG_WIDTH]    = out_tag_q;
            end else begin
                tree_valid_o[i] = 1'b0;
            end
        end
    end

    assign busy_o = (|buf_valid_q) | out_valid_q;

endmodule

// File: tb/tb_l2_resp_scheduler.sv
// Scoreboard bench for l2_resp_scheduler: the stimulus process pushes expected
// responses into per-instance queues, and a negedge monitor compares whatever
// the DUTs present on the tree against the queue heads.
module tb_l2_resp_scheduler;

    typedef struct packed {
        logic [1:0]  lane;
        logic [63:0] data;
        logic [7:0]  tag;
    } exp_t;

    logic clk;
    logic rst;

    logic [3:0]   bv4, br4, tv4;
    logic [255:0] bd4, td4;
    logic [31:0]  bt4, tt4;
    logic         rr4, busy4;

    logic [2:0]   bv3, br3, tv3;
    logic [191:0] bd3, td3;
    logic [23:0]  bt3, tt3;
    logic         rr3, busy3;

    logic [0:0]   bv1, br1, tv1;
    logic [63:0]  bd1, td1;
    logic [7:0]   bt1, tt1;
    logic         rr1, busy1;

    exp_t q4[$];
    exp_t q3[$];
    exp_t q1[$];

    int          want   [3][4];
    int          sent   [3][4];
    logic [63:0] base_d [3][4];
    logic [7:0]  base_t [3][4];

    logic       chk_en;
    logic [3:0] chk_tv;
    logic       chk_busy;
    logic [3:0] chk_br;
    logic       nobubble_en;
    logic       drain_req;

    int n_cmp  = 0;
    int n_fail = 0;

    l2_resp_scheduler #(.N_SLAVE(4), .DATA_WIDTH(64)) u4 (
        .clk(clk), .rst(rst),
        .bank_valid_i(bv4), .bank_rdata_i(bd4), .bank_rtag_i(bt4), .bank_ready_o(br4),
        .tree_valid_o(tv4), .tree_rdata_o(td4), .tree_rtag_o(tt4),
        .resp_ready_i(rr4), .busy_o(busy4)
    );

    l2_resp_scheduler #(.N_SLAVE(3), .DATA_WIDTH(64)) u3 (
        .clk(clk), .rst(rst),
        .bank_valid_i(bv3), .bank_rdata_i(bd3), .bank_rtag_i(bt3), .bank_ready_o(br3),
        .tree_valid_o(tv3), .tree_rdata_o(td3), .tree_rtag_o(tt3),
        .resp_ready_i(rr3), .busy_o(busy3)
    );

    l2_resp_scheduler #(.N_SLAVE(1), .DATA_WIDTH(64)) u1 (
        .clk(clk), .rst(rst),
        .bank_valid_i(bv1), .bank_rdata_i(bd1), .bank_rtag_i(bt1), .bank_ready_o(br1),
        .tree_valid_o(tv1), .tree_rdata_o(td1), .tree_rtag_o(tt1),
        .resp_ready_i(rr1), .busy_o(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void cmp(string nm, logic [63:0] act, logic [63:0] exp_v);
        n_cmp = n_cmp + 1;
        if (act !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endfunction

    function automatic void check(string nm, logic [3:0] tv, logic [255:0] td,
                                  logic [31:0] tt, exp_t e);
        logic [255:0] td_o;
        logic [31:0]  tt_o;
        int           ln;
        ln   = int'(e.lane);
        td_o = td;
        tt_o = tt;
        td_o[ln*64 +: 64] = 64'd0;
        tt_o[ln*8 +: 8]   = 8'd0;
        cmp({nm, "_valid"}, 64'(tv), 64'(4'b0001 << e.lane));
        cmp({nm, "_data"}, td[ln*64 +: 64], e.data);
        cmp({nm, "_tag"}, 64'(tt[ln*8 +: 8]), 64'(e.tag));
        cmp({nm, "_idle_lanes"}, 64'((|td_o) | (|tt_o)), 64'd0);
    endfunction

    function automatic exp_t mk(int lane, logic [63:0] d, logic [7:0] t);
        exp_t e;
        e.lane = 2'(lane);
        e.data = d;
        e.tag  = t;
        return e;
    endfunction

    // Monitor: compares tree outputs to the queue heads, pops on acceptance.
    always @(negedge clk) begin
        if (tv4 != 4'b0) begin
            if (q4.size() == 0) cmp("u4_unexpected", 64'(tv4), 64'd0);
            else begin
                check("u4", tv4, td4, tt4, q4[0]);
                if (rr4) q4.delete(0);
            end
        end
        if (tv3 != 3'b0) begin
            if (q3.size() == 0) cmp("u3_unexpected", 64'(tv3), 64'd0);
            else begin
                check("u3", {1'b0, tv3}, {64'd0, td3}, {8'd0, tt3}, q3[0]);
                if (rr3) q3.delete(0);
            end
        end
        if (tv1 != 1'b0) begin
            if (q1.size() == 0) cmp("u1_unexpected", 64'(tv1), 64'd0);
            else begin
                check("u1", {3'b0, tv1}, {192'd0, td1}, {24'd0, tt1}, q1[0]);
                if (rr1) q1.delete(0);
            end
        end
        if (chk_en) begin
            cmp("u4_tree_valid_state", 64'(tv4), 64'(chk_tv));
            cmp("u4_busy_state", 64'(busy4), 64'(chk_busy));
            cmp("u4_bank_ready_state", 64'(br4), 64'(chk_br));
        end
        if (nobubble_en) cmp("u4_no_bubble", 64'(|tv4), 64'd1);
        if (drain_req) begin
            cmp("u4_drained", 64'(q4.size()), 64'd0);
            cmp("u3_drained", 64'(q3.size()), 64'd0);
            cmp("u1_drained", 64'(q1.size()), 64'd0);
            cmp("u4_idle_busy", 64'(busy4), 64'd0);
            cmp("u3_idle_busy", 64'(busy3), 64'd0);
            cmp("u1_idle_busy", 64'(busy1), 64'd0);
        end
    end

    // One clock of bank stimulus: each bank offers its next sequence item while
    // it still has items left, and counts it as sent on a valid&ready cycle.
    task automatic step();
        for (int b = 0; b < 4; b++) begin
            bv4[b]          = (sent[0][b] < want[0][b]);
            bd4[b*64 +: 64] = base_d[0][b] + 64'(sent[0][b]);
            bt4[b*8 +: 8]   = base_t[0][b] + 8'(sent[0][b]);
        end
        for (int b = 0; b < 3; b++) begin
            bv3[b]          = (sent[1][b] < want[1][b]);
            bd3[b*64 +: 64] = base_d[1][b] + 64'(sent[1][b]);
            bt3[b*8 +: 8]   = base_t[1][b] + 8'(sent[1][b]);
        end
        bv1[0] = (sent[2][0] < want[2][0]);
        bd1    = base_d[2][0] + 64'(sent[2][0]);
        bt1    = base_t[2][0] + 8'(sent[2][0]);
        @(negedge clk);
        for (int b = 0; b < 4; b++) if (bv4[b] && br4[b]) sent[0][b] = sent[0][b] + 1;
        for (int b = 0; b < 3; b++) if (bv3[b] && br3[b]) sent[1][b] = sent[1][b] + 1;
        if (bv1[0] && br1[0]) sent[2][0] = sent[2][0] + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++)
            for (int b = 0; b < 4; b++) begin
                want[d][b] = 0;
                sent[d][b] = 0;
            end
        rr4 = 1'b1; rr3 = 1'b1; rr1 = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    // Bounded wait for all expected responses, then a few idle cycles to catch
    // extra outputs; an expired bound shows up as a non-empty queue.
    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (q4.size() == 0 && q3.size() == 0 && q1.size() == 0) break;
            step();
        end
        repeat (3) step();
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        chk_en = 1'b1; chk_tv = 4'b0000; chk_busy = 1'b0; chk_br = 4'b1111;
        nobubble_en = 1'b0;
        drain_req = 1'b0;
        rr4 = 1'b1; rr3 = 1'b1; rr1 = 1'b1;
        for (int d = 0; d < 3; d++)
            for (int b = 0; b < 4; b++) begin
                want[d][b] = 0; sent[d][b] = 0;
                base_d[d][b] = 64'd0; base_t[d][b] = 8'd0;
            end

        // Reset state, during and just after reset
        step(); step();
        rst = 1'b0;
        step();
        chk_en = 1'b0;

        // Single response from bank 2
        do_reset();
        base_d[0][2] = 64'hDEAD_BEEF_0000_0002;
        base_t[0][2] = 8'h5A;
        want[0][2] = 1;
        q4.push_back(mk(2, 64'hDEAD_BEEF_0000_0002, 8'h5A));
        drain();

        // Reset mid-operation: out holds bank 0, buffers hold banks 1 and 2
        do_reset();
        for (int b = 0; b < 3; b++) begin
            base_d[0][b] = 64'hC000_0000_0000_0000 + (64'(b) << 32);
            base_t[0][b] = 8'(8'hC0 + 8'(b << 4));
            want[0][b] = 1;
        end
        rr4 = 1'b0;
        q4.push_back(mk(0, 64'hC000_0000_0000_0000, 8'hC0));
        step(); step();
        chk_en = 1'b1; chk_tv = 4'b0001; chk_busy = 1'b1; chk_br = 4'b1001;
        step();
        rst = 1'b1;
        q4.delete();
        chk_tv = 4'b0000; chk_busy = 1'b0; chk_br = 4'b1111;
        step();
        rst = 1'b0;
        step();
        chk_en = 1'b0;
        want[0][0] = 2; want[0][2] = 2; rr4 = 1'b1;
        q4.push_back(mk(0, 64'hC000_0000_0000_0001, 8'hC1));
        q4.push_back(mk(2, 64'hC000_0002_0000_0001, 8'hE1));
        drain();

        // Round robin with all four banks streaming, 3 items each
        do_reset();
        for (int b = 0; b < 4; b++) begin
            base_d[0][b] = 64'hA000_0000_0000_0000 + (64'(b) << 32);
            base_t[0][b] = 8'(b << 4);
            want[0][b] = 3;
        end
        for (int r = 0; r < 3; r++)
            for (int b = 0; b < 4; b++)
                q4.push_back(mk(b, 64'hA000_0000_0000_0000 + (64'(b) << 32) + 64'(r),
                                8'(8'(b << 4) + 8'(r))));
        step(); step();
        nobubble_en = 1'b1;
        repeat (12) step();
        nobubble_en = 1'b0;
        drain();

        // Backpressure: banks 1 and 3, master stalled
        do_reset();
        base_d[0][1] = 64'h1111_0000_0000_0000; base_t[0][1] = 8'h11;
        base_d[0][3] = 64'h3333_0000_0000_0000; base_t[0][3] = 8'h33;
        want[0][1] = 1; want[0][3] = 1;
        rr4 = 1'b0;
        q4.push_back(mk(1, 64'h1111_0000_0000_0000, 8'h11));
        q4.push_back(mk(3, 64'h3333_0000_0000_0000, 8'h33));
        step(); step();
        chk_en = 1'b1; chk_tv = 4'b0010; chk_busy = 1'b1; chk_br = 4'b0111;
        repeat (4) step();
        chk_en = 1'b0;
        rr4 = 1'b1;
        drain();

        // Bank 0 back-to-back, tags 0..15, no bubble
        do_reset();
        base_d[0][0] = 64'h5000_0000_0000_0000; base_t[0][0] = 8'h00;
        want[0][0] = 16;
        for (int s = 0; s < 16; s++)
            q4.push_back(mk(0, 64'h5000_0000_0000_0000 + 64'(s), 8'(s)));
        step(); step();
        nobubble_en = 1'b1;
        repeat (16) step();
        nobubble_en = 1'b0;
        drain();

        // Parameterisation: three banks and a single bank
        do_reset();
        for (int b = 0; b < 3; b++) begin
            base_d[1][b] = 64'h3000_0000_0000_0000 + (64'(b) << 32);
            base_t[1][b] = 8'(8'h30 + 8'(b << 2));
            want[1][b] = 2;
        end
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < 3; b++)
                q3.push_back(mk(b, 64'h3000_0000_0000_0000 + (64'(b) << 32) + 64'(r),
                                8'(8'h30 + 8'(b << 2) + 8'(r))));
        base_d[2][0] = 64'h0100_0000_0000_0000; base_t[2][0] = 8'h80;
        want[2][0] = 4;
        for (int s = 0; s < 4; s++)
            q1.push_back(mk(0, 64'h0100_0000_0000_0000 + 64'(s), 8'(8'h80 + 8'(s))));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
